load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage placed directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3, and runs one data-memory transaction over a req/gnt/rvalid handshake.
- Returns sign/zero-extended load data and a completion pulse.
- Holds the pipeline stalled via busy_o while a transaction is outstanding; flags misaligned or illegal accesses without touching memory.

Parameters:
- WIDTH, 32, datapath and address width (only 32 supported; 4 byte lanes).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  request from execute stage; sampled only in IDLE.
- we_i  input  1  1 = store, 0 = load.
- funct3_i  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr_i  input  WIDTH  effective address (ALU output).
- wdata_i  input  WIDTH  store data (rs2).
- busy_o  output  1  high whenever state != IDLE; upstream must stall.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  one-cycle pulse, coincident with done_o, for misaligned/illegal access.
- rdata_o  output  WIDTH  extended load result, valid when done_o and load.
- mem_req_o  output  1  memory request, held until mem_gnt_i.
- mem_we_o  output  1  write enable.
- mem_addr_o  output  WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_be_o  output  4  byte enables.
- mem_wdata_o  output  WIDTH  lane-replicated store data.
- mem_gnt_i  input  1  memory accepts request this cycle.
- mem_rvalid_i  input  1  read data valid (never in the same cycle as its gnt).
- mem_rdata_i  input  WIDTH  read word.

Behaviour:
- Reset: state IDLE; busy_o, done_o, err_o, mem_req_o, mem_we_o = 0; rdata_o, mem_addr_o, mem_be_o, mem_wdata_o = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - valid_i=1 captures we, funct3, addr[1:0], and wdata.
  - Legal access: go to REQ, with mem_req_o and the mem_* fields registered so they appear the next cycle.
  - Illegal access: stay in IDLE, pulse done_o=1 and err_o=1 next cycle; no memory request; rdata_o unchanged.
- Illegal access definitions:
  - H/HU/SH with addr[0]=1.
  - W with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 >= 011.
- REQ:
  - mem_req_o and all mem_* fields held stable until mem_gnt_i.
  - On gnt, mem_req_o drops next cycle.
  - Store: go to IDLE and pulse done_o next cycle.
  - Load: go to WAIT.
- WAIT: on mem_rvalid_i, register the extended result into rdata_o, pulse done_o next cycle, and go to IDLE.
- Minimum latency (valid_i to done_o):
  - Store: 2 cycles when gnt is high in the first REQ cycle.
  - Load: 3 cycles when gnt is high in the first REQ cycle and rvalid comes the following cycle.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1).
  - W: 4'b1111.
  - Loads also drive the matching be.
- Store data: B replicates wdata[7:0] into all four lanes; H replicates wdata[15:0] twice; W passes through.
- Load extract:
  - Byte lane = mem_rdata_i[8*addr[1:0] +: 8].
  - Halfword = mem_rdata_i[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- valid_i while busy_o=1: ignored; no queueing.
- done_o is high for exactly one cycle per accepted request. busy_o falls in the same cycle done_o rises, so a new request may be accepted in the done_o cycle.
- rdata_o holds its last value until the next load completes.
- mem_gnt_i/mem_rvalid_i arriving outside REQ/WAIT respectively are ignored.
- rst mid-transaction: immediate return to IDLE with all outputs at reset values next cycle. A late rvalid from the aborted load is ignored.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, gnt in first REQ cycle, rvalid next cycle -> mem_addr_o=0x100, be=1111, done_o at cycle 3, rdata_o=0xDEADBEEF, busy_o high cycles 1-2.
- LB addr=0x103 and LBU addr=0x103, rdata=0x80FF7F01 -> be=1000; rdata_o=0xFFFFFF80 for LB, 0x00000080 for LBU. LH addr=0x102 -> 0xFFFF80FF.
- SB addr=0x201, wdata=0x123456AB -> mem_addr_o=0x200, be=0010, mem_wdata_o=0xABABABAB, mem_we_o=1, done at cycle 2. SH addr=0x202, wdata=0xCAFE -> be=1100, wdata=0xCAFECAFE.
- gnt held low 5 cycles during SW -> mem_req_o and all mem_* fields stable for all 5 cycles; done_o exactly one cycle after gnt.
- LW addr=0x101, and SH addr=0x3 -> no mem_req_o; done_o=err_o=1 one cycle after valid_i; busy_o never high. funct3=011 load -> same.
- rst asserted in WAIT, then rvalid arrives -> outputs 0, state IDLE, no done_o; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and memory: a req/gnt address
// phase followed, for loads only, by an rvalid data phase.
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: the master raises mem_req_o with every mem_* field stable and
    // holds them until a cycle in which mem_gnt_i is high; that cycle is the
    // transfer. A load then completes when mem_rvalid_i is high, with
    // mem_rdata_i valid in that same cycle. rvalid never coincides with its
    // own gnt.
    logic             mem_req_o;
    logic             mem_we_o;
    logic [WIDTH-1:0] mem_addr_o;
    logic [3:0]       mem_be_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic             mem_gnt_i;
    logic             mem_rvalid_i;
    logic [WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: runs one data-memory transaction per accepted request and
// returns extended load data, or flags misaligned/illegal accesses locally.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [WIDTH-1:0]  addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [WIDTH-1:0]  rdata_o,
    output logic [1:0]        dbg_state,
    load_store_unit_if.master mem
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic             done_q, err_q;
    logic [WIDTH-1:0] rdata_q;
    logic             accept, reject, store_done, load_done;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad_code, misaligned;
        bad_code = we ? (f3 >= 3'b011)
                      : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return bad_code || misaligned;
    endfunction

    function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] store_lanes(input logic [2:0] f3,
                                                     input logic [WIDTH-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        reject     = 1'b0;
        store_done = 1'b0;
        load_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (is_illegal(we_i, funct3_i, addr_i[1:0])) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_gnt_i) begin
                    // Stores finish at grant; loads still owe a data phase.
                    if (mem.mem_we_o) begin
                        store_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_rvalid_i) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q        <= 3'd0;
            off_q           <= 2'd0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            rdata_q         <= '0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_be_o    <= 4'd0;
            mem.mem_wdata_o <= '0;
        end else begin
            done_q <= reject | store_done | load_done;
            err_q  <= reject;
            if (accept) begin
                funct3_q        <= funct3_i;
                off_q           <= addr_i[1:0];
                mem.mem_req_o   <= 1'b1;
                mem.mem_we_o    <= we_i;
                mem.mem_addr_o  <= {addr_i[WIDTH-1:2], 2'b00};
                mem.mem_be_o    <= be_for(funct3_i, addr_i[1:0]);
                mem.mem_wdata_o <= store_lanes(funct3_i, wdata_i);
            end
            if (state_q == REQ && mem.mem_gnt_i) mem.mem_req_o <= 1'b0;
            if (load_done) rdata_q <= load_extend(funct3_q, off_q, mem.mem_rdata_i);
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// back-to-back traffic against a byte-level reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [1:0]  dbg_state;

    load_store_unit_if #(.WIDTH(32)) mem_bus ();

    load_store_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid),
        .we_i      (we),
        .funct3_i  (funct3),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .rdata_o   (rdata),
        .dbg_state (dbg_state),
        .mem       (mem_bus.master)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [31:0] exp_q[$];

    // Observations recorded by the driver for one transaction.
    int          obs_done_cyc, obs_gnt_cyc, obs_busy_cycles, obs_req_cycles;
    bit          obs_saw_req, obs_stable;
    logic        obs_err, obs_we;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    // ---------------- reference model ----------------
    function automatic int nbytes_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_illegal(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (w && f3 > 3'd2) return 1'b1;
        if (!w && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        return (a % nbytes_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes_of(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes_of(f3);
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] word);
        logic [31:0] v, mask;
        int n;
        n = nbytes_of(f3);
        if (n == 4) return word;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (word >> (8 * (a % 4))) & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int gnt_delay, input int rv_delay,
                           input logic [31:0] word, input bit junk_valid);
        int req_cycles, wait_cycles;
        bit gnt_given;
        obs_done_cyc = -1; obs_gnt_cyc = -1; obs_busy_cycles = 0; obs_req_cycles = 0;
        obs_saw_req = 0; obs_stable = 1; obs_err = 0; obs_rdata = 32'd0;
        obs_we = 0; obs_addr = 32'd0; obs_be = 4'd0; obs_wdata = 32'd0;
        req_cycles = 0; wait_cycles = 0; gnt_given = 0;
        valid = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        mem_bus.mem_gnt_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 60; c++) begin
            valid = 1'b0;
            mem_bus.mem_gnt_i = 1'b0;
            mem_bus.mem_rvalid_i = 1'b0;
            mem_bus.mem_rdata_i = $urandom();
            if (done) begin
                obs_done_cyc = c; obs_err = err; obs_rdata = rdata;
                break;
            end
            if (busy) obs_busy_cycles++;
            if (mem_bus.mem_req_o) begin
                if (!obs_saw_req) begin
                    obs_we = mem_bus.mem_we_o; obs_addr = mem_bus.mem_addr_o;
                    obs_be = mem_bus.mem_be_o; obs_wdata = mem_bus.mem_wdata_o;
                end else if ({mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_be_o,
                              mem_bus.mem_wdata_o} !== {obs_we, obs_addr, obs_be, obs_wdata}) begin
                    obs_stable = 0;
                end
                obs_saw_req = 1;
                if (req_cycles == gnt_delay) begin
                    mem_bus.mem_gnt_i = 1'b1; obs_gnt_cyc = c; gnt_given = 1;
                end else if (junk_valid) begin
                    valid = 1'b1; we = ~w; funct3 = 3'b010; addr = $urandom(); wdata = $urandom();
                end
                req_cycles++;
            end else if (gnt_given && !w) begin
                if (wait_cycles == rv_delay) begin
                    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = word;
                end
                wait_cycles++;
            end
            @(posedge clk); #1;
        end
        obs_req_cycles = req_cycles;
        mem_bus.mem_gnt_i = 1'b0;
        mem_bus.mem_rvalid_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h55;
        mem_bus.mem_gnt_i = 1'b1; mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if ({busy, done, err} !== 3'b000)
            $display("FAIL reset_ctrl: busy/done/err=%b expected 000", {busy, done, err});
        else checks_passed++;
        checks_total++;
        if ({mem_bus.mem_req_o, mem_bus.mem_we_o} !== 2'b00)
            $display("FAIL reset_req: req/we=%b expected 00", {mem_bus.mem_req_o, mem_bus.mem_we_o});
        else checks_passed++;
        checks_total++;
        if ({rdata, mem_bus.mem_addr_o, mem_bus.mem_be_o, mem_bus.mem_wdata_o} !== 100'd0)
            $display("FAIL reset_data: rdata=%h addr=%h be=%b wdata=%h expected all zero",
                     rdata, mem_bus.mem_addr_o, mem_bus.mem_be_o, mem_bus.mem_wdata_o);
        else checks_passed++;
        rst = 1'b0; valid = 1'b0;
        mem_bus.mem_gnt_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        checks_total++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_we !== 1'b0)
            $display("FAIL lw_bus: addr=%h be=%b we=%b expected 00000100 1111 0", obs_addr, obs_be, obs_we);
        else checks_passed++;
        checks_total++;
        if (obs_done_cyc != 3)
            $display("FAIL lw_latency: done at cycle %0d expected 3", obs_done_cyc);
        else checks_passed++;
        checks_total++;
        if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0)
            $display("FAIL lw_data: rdata=%h err=%b expected deadbeef 0", obs_rdata, obs_err);
        else checks_passed++;
        checks_total++;
        if (obs_busy_cycles != 2)
            $display("FAIL lw_busy: busy for %0d cycles expected 2", obs_busy_cycles);
        else checks_passed++;
        last_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3_t[3]  = '{3'b000, 3'b100, 3'b001};
        logic [31:0] a_t[3]   = '{32'h103, 32'h103, 32'h102};
        logic [3:0]  be_t[3]  = '{4'b1000, 4'b1000, 4'b1100};
        logic [31:0] exp_t[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, f3_t[i], a_t[i], 32'h0, 0, 0, 32'h80FF7F01, 1'b0);
            checks_total++;
            if (obs_be !== be_t[i] || obs_addr !== 32'h100 || obs_rdata !== exp_t[i])
                $display("FAIL load_ext[%0d]: be=%b addr=%h rdata=%h expected %b 00000100 %h",
                         i, obs_be, obs_addr, obs_rdata, be_t[i], exp_t[i]);
            else checks_passed++;
            last_rdata = exp_t[i];
        end
    endtask

    task automatic test_store();
        run_txn(1'b1, 3'b000, 32'h201, 32'h123456AB, 0, 0, 32'h0, 1'b0);
        checks_total++;
        if (obs_addr !== 32'h200 || obs_be !== 4'b0010 || obs_wdata !== 32'hABABABAB || obs_we !== 1'b1)
            $display("FAIL sb_bus: addr=%h be=%b wdata=%h we=%b expected 00000200 0010 abababab 1",
                     obs_addr, obs_be, obs_wdata, obs_we);
        else checks_passed++;
        checks_total++;
        if (obs_done_cyc != 2 || obs_err !== 1'b0 || obs_rdata !== last_rdata)
            $display("FAIL sb_done: cycle=%0d err=%b rdata=%h expected 2 0 %h",
                     obs_done_cyc, obs_err, obs_rdata, last_rdata);
        else checks_passed++;
        run_txn(1'b1, 3'b001, 32'h202, 32'h0000CAFE, 0, 0, 32'h0, 1'b0);
        checks_total++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'hCAFECAFE || obs_done_cyc != 2)
            $display("FAIL sh_bus: be=%b wdata=%h done_cyc=%0d expected 1100 cafecafe 2",
                     obs_be, obs_wdata, obs_done_cyc);
        else checks_passed++;
    endtask

    task automatic test_gnt_stall();
        logic [31:0] d;
        d = $urandom();
        run_txn(1'b1, 3'b010, 32'h300, d, 5, 0, 32'h0, 1'b1);
        checks_total++;
        if (!obs_stable || obs_req_cycles != 6 || obs_wdata !== d || obs_addr !== 32'h300)
            $display("FAIL stall_hold: stable=%0d req_cycles=%0d wdata=%h addr=%h expected 1 6 %h 00000300",
                     obs_stable, obs_req_cycles, obs_wdata, obs_addr, d);
        else checks_passed++;
        checks_total++;
        if (obs_gnt_cyc < 0 || obs_done_cyc != obs_gnt_cyc + 1)
            $display("FAIL stall_done: done at %0d gnt at %0d expected done one after gnt",
                     obs_done_cyc, obs_gnt_cyc);
        else checks_passed++;
        @(posedge clk); #1;
        checks_total++;
        if (done !== 1'b0 || mem_bus.mem_req_o !== 1'b0)
            $display("FAIL stall_pulse: done=%b req=%b one cycle later expected 0 0", done, mem_bus.mem_req_o);
        else checks_passed++;
    endtask

    task automatic test_illegal();
        logic        w_t[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t[4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] a_t[4]  = '{32'h101, 32'h3, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_txn(w_t[i], f3_t[i], a_t[i], $urandom(), 0, 0, 32'h0, 1'b0);
            checks_total++;
            if (obs_saw_req || obs_done_cyc != 1 || obs_err !== 1'b1 || obs_busy_cycles != 0 ||
                obs_rdata !== last_rdata)
                $display("FAIL illegal[%0d]: req=%0d done_cyc=%0d err=%b busy_cycles=%0d rdata=%h expected 0 1 1 0 %h",
                         i, obs_saw_req, obs_done_cyc, obs_err, obs_busy_cycles, obs_rdata, last_rdata);
            else checks_passed++;
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] word;
        valid = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1;
        valid = 1'b0; mem_bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt_i = 1'b0;
        checks_total++;
        if (busy !== 1'b1 || mem_bus.mem_req_o !== 1'b0)
            $display("FAIL rst_mid_wait: busy=%b req=%b expected 1 0", busy, mem_bus.mem_req_o);
        else checks_passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks_total++;
        if ({busy, done, err, mem_bus.mem_req_o, mem_bus.mem_we_o} !== 5'b0 || rdata !== 32'd0 ||
            mem_bus.mem_addr_o !== 32'd0 || mem_bus.mem_be_o !== 4'd0)
            $display("FAIL rst_mid_outputs: busy=%b done=%b req=%b rdata=%h addr=%h be=%b expected all zero",
                     busy, done, mem_bus.mem_req_o, rdata, mem_bus.mem_addr_o, mem_bus.mem_be_o);
        else checks_passed++;
        mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'h11223344;
        @(posedge clk); #1;
        mem_bus.mem_rvalid_i = 1'b0;
        checks_total++;
        if (done !== 1'b0 || rdata !== 32'd0 || busy !== 1'b0)
            $display("FAIL rst_mid_late_rvalid: done=%b rdata=%h busy=%b expected 0 00000000 0", done, rdata, busy);
        else checks_passed++;
        last_rdata = 32'd0;
        word = $urandom();
        run_txn(1'b0, 3'b010, 32'h44, 32'h0, 0, 0, word, 1'b0);
        checks_total++;
        if (obs_done_cyc != 3 || obs_rdata !== word || obs_addr !== 32'h44)
            $display("FAIL rst_mid_recover: done_cyc=%0d rdata=%h addr=%h expected 3 %h 00000044",
                     obs_done_cyc, obs_rdata, obs_addr, word);
        else checks_passed++;
        last_rdata = word;
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 60; n++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a, d, word, exp_r;
            int          gd, rd, exp_cyc;
            bit          bad;
            w = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
            a = $urandom(); d = $urandom(); word = $urandom();
            gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            bad = model_illegal(w, f3, a);
            exp_r = (!bad && !w) ? model_rdata(f3, a, word) : last_rdata;
            exp_cyc = bad ? 1 : (w ? gd + 2 : gd + rd + 3);
            exp_q.push_back(exp_r);
            run_txn(w, f3, a, d, gd, rd, word, 1'($urandom_range(0, 1)));
            exp_r = exp_q.pop_front();
            checks_total++;
            if (obs_done_cyc != exp_cyc || obs_err !== bad || obs_rdata !== exp_r)
                $display("FAIL rand[%0d] done: we=%b f3=%b addr=%h cyc=%0d err=%b rdata=%h expected %0d %b %h",
                         n, w, f3, a, obs_done_cyc, obs_err, obs_rdata, exp_cyc, bad, exp_r);
            else checks_passed++;
            last_rdata = exp_r;
            if (!bad) begin
                checks_total++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_be !== model_be(f3, a) || obs_we !== w ||
                    !obs_stable || (w && obs_wdata !== model_wdata(f3, d)))
                    $display("FAIL rand[%0d] bus: addr=%h be=%b we=%b wdata=%h stable=%0d expected %h %b %b %h 1",
                             n, obs_addr, obs_be, obs_we, obs_wdata, obs_stable,
                             {a[31:2], 2'b00}, model_be(f3, a), w, model_wdata(f3, d));
                else checks_passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_bus.mem_gnt_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0; mem_bus.mem_rdata_i = 32'd0;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_gnt_stall();
        test_illegal();
        test_rst_mid();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
